decode_arith_stage: RTL

//  Registered decode stage for RISC-V integer arithmetic: OP-IMM, OP and (XLEN=64) OP-IMM-32/OP-32.

---
 rtl/decode_arith_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_arith_stage.sv
// -----------------------------------------------------------------------------
// decode_arith_stage
//
// Registered decode stage for RISC-V integer arithmetic. It handles OP-IMM and
// OP, and with XLEN=64 also OP-IMM-32 and OP-32. One clock of latency sits
// between a valid/ready handshake on the fetch side and one on the issue side.
// A two-entry buffer (main + skid) keeps full throughput, so in_ready can be a
// plain flop output. A saturating counter records how many illegal entries the
// consumer has taken.
//
// Parameters
//   XLEN   datapath width, 32 or 64 only (any other value stops elaboration)
//   CNT_W  width of illegal_count
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-low
//   flush          drop every buffered entry; wins over an accept
//   in_valid       in_instr holds a word
//   in_ready       stage can take a word (registered: ~skid full)
//   in_instr[31:0] raw instruction word
//   out_valid      decoded entry on out_* is valid
//   out_ready      consumer takes the entry
//   out_op[4:0]    op code: 0 invalid, 1 add, 2 sub, 3 sll, 4 slt, 5 sltu,
//                  6 xor, 7 srl, 8 sra, 9 or, 10 and, 11..18 mul, mulh,
//                  mulhsu, mulhu, div, divu, rem, remu (M extension only)
//   out_is_imm     operand 2 is out_imm
//   out_is_word    *W form (always 0 when XLEN=32)
//   out_rd/rs1/rs2 register indices; rs2 is 0 for immediate forms
//   out_imm        sign-extended imm[11:0], or zero-extended shamt for shifts
//   out_illegal    entry is not a legal arithmetic encoding (out_op is 0)
//   illegal_count  illegal entries handed to the consumer, saturating
//
// Build option
//   DECODE_ARITH_M_EXT_EN  when defined, funct7=0000001 on OP/OP-32 decodes to
//                          the M-extension ops; otherwise it is illegal.
// -----------------------------------------------------------------------------
module decode_arith_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_op,
  output logic             out_is_imm,
  output logic             out_is_word,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_arith_stage: XLEN must be 32 or 64");
  end

  localparam bit IS64 = (XLEN == 64);

`ifdef DECODE_ARITH_M_EXT_EN
  localparam bit M_EXT = 1'b1;
`else
  localparam bit M_EXT = 1'b0;
`endif

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [4:0] {
    OP_INVALID = 5'd0,
    OP_ADD     = 5'd1,
    OP_SUB     = 5'd2,
    OP_SLL     = 5'd3,
    OP_SLT     = 5'd4,
    OP_SLTU    = 5'd5,
    OP_XOR     = 5'd6,
    OP_SRL     = 5'd7,
    OP_SRA     = 5'd8,
    OP_OR      = 5'd9,
    OP_AND     = 5'd10,
    OP_MUL     = 5'd11,
    OP_MULH    = 5'd12,
    OP_MULHSU  = 5'd13,
    OP_MULHU   = 5'd14,
    OP_DIV     = 5'd15,
    OP_DIVU    = 5'd16,
    OP_REM     = 5'd17,
    OP_REMU    = 5'd18
  } op_e;

  typedef struct packed {
    op_e             op;
    logic            is_imm;
    logic            is_word;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  // funct3 -> base op; alt selects sub/sra on the funct3 codes that have one.
  function automatic op_e base_op(input logic [2:0] f3, input logic alt);
    op_e op;
    case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction field extraction
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic            is_shift;
  logic            alt_shift;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_shamt5;
  logic [XLEN-1:0] imm_shamt6;
  logic            shift32_ok;
  logic            shift64_ok;
  op_e             mul_op;

  assign opcode     = in_instr[6:0];
  assign funct3     = in_instr[14:12];
  assign funct7     = in_instr[31:25];
  assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Only the right shift has an arithmetic variant, selected by bit 30.
  assign alt_shift  = (funct3 == 3'b101) && in_instr[30];
  assign imm_sext   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_shamt5 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign imm_shamt6 = {{(XLEN-6){1'b0}}, in_instr[25:20]};
  assign mul_op     = op_e'(5'd11 + {2'b00, funct3});

  // 5-bit shamt form (RV32 immediates and every W shift): upper field is the
  // funct7 value, and the 0100000 variant exists only for the right shift.
  assign shift32_ok = (funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && (funct3 == 3'b101));
  // 6-bit shamt form on RV64: bit 25 belongs to shamt, so only imm[11:6] is
  // checked.
  assign shift64_ok = (in_instr[31:26] == 6'b000000) ||
                      ((in_instr[31:26] == 6'b010000) && (funct3 == 3'b101));

  // ---------------------------------------------------------------------------
  // Decode of the incoming word
  // ---------------------------------------------------------------------------
  entry_t dec;
  logic   legal;

  // NOTE: every signal written in this block gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    dec         = '0;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.imm     = imm_sext;
    dec.op      = OP_INVALID;
    legal       = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        dec.is_imm = 1'b1;
        dec.rs2    = 5'd0;
        dec.op     = base_op(funct3, alt_shift);
        if (is_shift) begin
          dec.imm = IS64 ? imm_shamt6 : imm_shamt5;
          legal   = IS64 ? shift64_ok : shift32_ok;
        end else begin
          legal   = 1'b1;
        end
      end

      OPC_OP: begin
        case (funct7)
          F7_BASE: begin
            legal  = 1'b1;
            dec.op = base_op(funct3, 1'b0);
          end
          F7_ALT: begin
            legal  = (funct3 == 3'b000) || (funct3 == 3'b101);
            dec.op = base_op(funct3, 1'b1);
          end
          F7_MUL: begin
            legal  = M_EXT;
            dec.op = mul_op;
          end
          default: legal = 1'b0;
        endcase
      end

      OPC_OP_IMM_32: begin
        if (IS64) begin
          dec.is_imm  = 1'b1;
          dec.is_word = 1'b1;
          dec.rs2     = 5'd0;
          if (funct3 == 3'b000) begin
            legal  = 1'b1;
            dec.op = OP_ADD;
          end else if (is_shift) begin
            dec.imm = imm_shamt5;
            legal   = shift32_ok;
            dec.op  = base_op(funct3, alt_shift);
          end
        end
      end

      OPC_OP_32: begin
        if (IS64) begin
          dec.is_word = 1'b1;
          case (funct7)
            F7_BASE: begin
              legal  = (funct3 == 3'b000) || is_shift;
              dec.op = base_op(funct3, 1'b0);
            end
            F7_ALT: begin
              legal  = (funct3 == 3'b000) || (funct3 == 3'b101);
              dec.op = base_op(funct3, 1'b1);
            end
            F7_MUL: begin
              // mulw plus the four divide/remainder forms (funct3 1xx).
              legal  = M_EXT && ((funct3 == 3'b000) || funct3[2]);
              dec.op = mul_op;
            end
            default: legal = 1'b0;
          endcase
        end
      end

      default: legal = 1'b0;
    endcase

    dec.illegal = ~legal;
    if (!legal) begin
      dec.op = OP_INVALID;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry buffer: main drives out_*, skid catches a word accepted while
  // main is stalled. in_ready is ~skid_valid_q, so nothing arrives while the
  // skid entry is occupied.
  // ---------------------------------------------------------------------------
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic xfer;

  assign accept = in_valid && in_ready;
  assign xfer   = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: accept is impossible; a transfer promotes skid to main.
      if (xfer) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      case ({xfer, accept})
        2'b11: main_d = dec;
        2'b10: main_valid_d = 1'b0;
        2'b01: begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
        default: ;
      endcase
    end else if (accept) begin
      main_d       = dec;
      main_valid_d = 1'b1;
    end
  end

  // The counter sees every transfer, including one in a flush cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && main_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the data entries are reset as well as the valid bits, because the
  // out_* fields must read zero after reset, not whatever was last captured.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready      = ~skid_valid_q;
  assign out_valid     = main_valid_q;
  assign out_op        = main_q.op;
  assign out_is_imm    = main_q.is_imm;
  assign out_is_word   = main_q.is_word;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_imm       = main_q.imm;
  assign out_illegal   = main_q.illegal;
  assign illegal_count = cnt_q;

endmodule
